// File: rtl/vid_pkg.sv
// Shared video definitions: FSM state encoding and default pixel constants.
package vid_pkg;
   localparam int DW_DEF = 24;
   localparam logic [DW_DEF-1:0] FILL_DEF = 24'h000000;

   typedef enum logic [1:0] {
      WAIT_VS = 2'b01,
      ACTIVE  = 2'b10
   } state_t;
endpackage

// File: rtl/vid_edge_det.sv
// Registered 1-bit rise/fall detector, updated every clock.
module vid_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);
   logic r_d;

   always_ff @(posedge clk) begin
      if (!rst_n) r_d <= 1'b0;
      else        r_d <= i_sig;
   end

   assign o_rise = i_sig & ~r_d;
   assign o_fall = ~i_sig & r_d;
endmodule

// File: rtl/vid_pix_out.sv
// Pixel output stage: drains a show-ahead FIFO under the timing generator's
// data window and emits a registered stream with SOF/SOL and sticky errors.
module vid_pix_out
   import vid_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int PIX_PER_LINE = 16,
   parameter int LINES = 2,
   parameter logic [DW-1:0] FILL = DW'(FILL_DEF)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          hsync,
   input  logic          vsync,
   input  logic          daten,
   input  logic [DW-1:0] fifo_dat,
   input  logic          fifo_empty,
   output logic          fifo_rd,
   output logic [DW-1:0] pix_dat,
   output logic          pix_vld,
   output logic          pix_sof,
   output logic          pix_sol,
   output logic [7:0]    line_cnt,
   output logic          frame_done,
   input  logic          err_clr,
   output logic          underrun,
   output logic          len_err,
   output logic          frm_err
);
   localparam logic [15:0] PPL = 16'(PIX_PER_LINE);
   localparam logic [7:0]  NL  = 8'(LINES);

   state_t        r_state, w_state_nxt;
   logic [15:0]   r_pix_cnt, w_pix_nxt;
   logic [7:0]    r_line_cnt, w_line_nxt, w_line_inc;
   logic [DW-1:0] r_pix_dat;
   logic          r_pix_vld, r_sof, r_sol, r_done;
   logic          r_und, r_len, r_frm;
   logic          w_vs_rise, w_vs_fall, w_de_rise, w_de_fall;
   logic          w_pt, w_done, w_len_set, w_frm_set;
   logic          w_unused;

   vid_edge_det u_vs (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sig  (vsync),
      .o_rise (w_vs_rise),
      .o_fall (w_vs_fall)
   );

   vid_edge_det u_de (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sig  (daten),
      .o_rise (w_de_rise),
      .o_fall (w_de_fall)
   );

   assign w_unused = ^{w_vs_fall, w_de_rise, hsync};

   assign w_pt    = ena & daten & (r_state == ACTIVE);
   assign fifo_rd = w_pt & ~fifo_empty;
   assign w_line_inc = r_line_cnt + 8'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_pix_nxt   = r_pix_cnt;
      w_line_nxt  = r_line_cnt;
      w_done      = 1'b0;
      w_len_set   = 1'b0;
      w_frm_set   = 1'b0;
      unique case (r_state)
         WAIT_VS: begin
            if (w_vs_rise) begin
               w_state_nxt = ACTIVE;
               w_pix_nxt   = '0;
               w_line_nxt  = '0;
            end
         end
         ACTIVE: begin
            if (w_pt && r_pix_cnt != 16'hFFFF)
               w_pix_nxt = r_pix_cnt + 16'd1;
            if (w_de_fall) begin
               w_len_set  = (r_pix_cnt != PPL);
               w_pix_nxt  = '0;
               w_line_nxt = w_line_inc;
               if (w_line_inc == NL) begin
                  w_done      = 1'b1;
                  w_state_nxt = WAIT_VS;
               end
            end
            // Line end is counted first; a vsync edge then restarts the frame.
            if (w_vs_rise) begin
               w_frm_set   = ~w_done;
               w_pix_nxt   = '0;
               w_line_nxt  = '0;
               w_state_nxt = ACTIVE;
            end
         end
         default: w_state_nxt = WAIT_VS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= WAIT_VS;
         r_pix_cnt  <= '0;
         r_line_cnt <= '0;
         r_pix_dat  <= '0;
         r_pix_vld  <= 1'b0;
         r_sof      <= 1'b0;
         r_sol      <= 1'b0;
         r_done     <= 1'b0;
         r_und      <= 1'b0;
         r_len      <= 1'b0;
         r_frm      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pix_cnt  <= w_pix_nxt;
         r_line_cnt <= w_line_nxt;
         r_done     <= w_done;
         r_pix_vld  <= w_pt;
         r_sol      <= w_pt & (r_pix_cnt == '0);
         r_sof      <= w_pt & (r_pix_cnt == '0) & (r_line_cnt == '0);
         if (w_pt) r_pix_dat <= fifo_empty ? FILL : fifo_dat;
         r_und <= (w_pt & fifo_empty) | (r_und & ~err_clr);
         r_len <= w_len_set | (r_len & ~err_clr);
         r_frm <= w_frm_set | (r_frm & ~err_clr);
      end
   end

   assign pix_dat    = r_pix_dat;
   assign pix_vld    = r_pix_vld;
   assign pix_sof    = r_sof;
   assign pix_sol    = r_sol;
   assign line_cnt   = r_line_cnt;
   assign frame_done = r_done;
   assign underrun   = r_und;
   assign len_err    = r_len;
   assign frm_err    = r_frm;
endmodule

// File: tb/tb_vid_pix_out.sv
// Self-checking bench for vid_pix_out: directed frame scenarios with random
// pixel data, scored against a frame-level reference model.
module tb_vid_pix_out;
   localparam int PPL = 16;
   localparam int NL  = 2;
   localparam logic [23:0] FILLV = 24'h000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        hsync = 1'b1;
   logic        vsync = 1'b0;
   logic        daten = 1'b0;
   logic [23:0] fifo_dat = '0;
   logic        fifo_empty = 1'b1;
   logic        fifo_rd;
   logic [23:0] pix_dat;
   logic        pix_vld, pix_sof, pix_sol;
   logic [7:0]  line_cnt;
   logic        frame_done;
   logic        err_clr = 1'b0;
   logic        underrun, len_err, frm_err;

   vid_pix_out #(
      .DW(24), .PIX_PER_LINE(PPL), .LINES(NL), .FILL(FILLV)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .hsync(hsync),
      .vsync(vsync), .daten(daten), .fifo_dat(fifo_dat),
      .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .pix_dat(pix_dat),
      .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_sol(pix_sol),
      .line_cnt(line_cnt), .frame_done(frame_done), .err_clr(err_clr),
      .underrun(underrun), .len_err(len_err), .frm_err(frm_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents, frame position and expected outputs.
   logic [23:0] fq[$];
   bit          m_act, m_vs, m_de;
   int          m_pix, m_line;
   bit          m_und, m_len, m_frm;
   logic [23:0] m_dat;
   bit          e_vld, e_sof, e_sol, e_done;
   bit          g_clr;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc(input bit rst, input bit e, input bit de, input bit vs);
      bit pt, vr, df, emp, lset, fset;
      rst_n = rst; ena = e; daten = de; hsync = ~de; vsync = vs;
      err_clr = g_clr;
      emp = (fq.size() == 0);
      fifo_empty = emp;
      fifo_dat = emp ? 24'($urandom) : fq[0];
      #1;
      pt = e & de & m_act;
      chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, pt & !emp});
      if (!rst) begin
         if (pt && !emp) void'(fq.pop_front());
         m_act = 0; m_pix = 0; m_line = 0;
         m_und = 0; m_len = 0; m_frm = 0; m_dat = '0;
         e_vld = 0; e_sof = 0; e_sol = 0; e_done = 0;
         m_vs = 0; m_de = 0;
      end else begin
         vr = vs & !m_vs;
         df = !de & m_de;
         lset = 0; fset = 0; e_done = 0;
         e_vld = pt;
         e_sol = pt && (m_pix == 0);
         e_sof = e_sol && (m_line == 0);
         if (pt) m_dat = emp ? FILLV : fq.pop_front();
         if (!m_act) begin
            if (vr) begin m_act = 1; m_pix = 0; m_line = 0; end
         end else begin
            if (pt && m_pix < 65535) m_pix++;
            if (df) begin
               lset = (m_pix != PPL);
               m_pix = 0;
               m_line++;
               if (m_line == NL) begin e_done = 1; m_act = 0; end
            end
            if (vr) begin
               fset = !e_done;
               m_pix = 0; m_line = 0; m_act = 1;
            end
         end
         m_und = (pt && emp) || (m_und && !g_clr);
         m_len = lset || (m_len && !g_clr);
         m_frm = fset || (m_frm && !g_clr);
         m_vs = vs; m_de = de;
      end
      @(posedge clk); #1;
      chk("pix_vld", {31'd0, pix_vld}, {31'd0, e_vld});
      chk("pix_dat", {8'd0, pix_dat}, {8'd0, m_dat});
      chk("pix_sof", {31'd0, pix_sof}, {31'd0, e_sof});
      chk("pix_sol", {31'd0, pix_sol}, {31'd0, e_sol});
      chk("line_cnt", {24'd0, line_cnt}, 32'(m_line));
      chk("frame_done", {31'd0, frame_done}, {31'd0, e_done});
      chk("underrun", {31'd0, underrun}, {31'd0, m_und});
      chk("len_err", {31'd0, len_err}, {31'd0, m_len});
      chk("frm_err", {31'd0, frm_err}, {31'd0, m_frm});
   endtask

   task automatic vsp();
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 0);
   endtask

   task automatic line(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         repeat (gap) cyc(1, 0, 1, 0);
         cyc(1, 1, 1, 0);
      end
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) fq.push_back(24'($urandom));
   endtask

   task automatic clr_pulse();
      g_clr = 1;
      cyc(1, 0, 0, 0);
      g_clr = 0;
   endtask

   initial begin
      g_clr = 0;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);

      // Nominal frame: words 1..32, ena every 2nd clk
      for (int i = 1; i <= 32; i++) fq.push_back(24'(i));
      vsp();
      line(PPL, 1);
      line(PPL, 1);
      cyc(1, 0, 0, 0);

      // Underrun: only 10 words available
      fill_rand(10);
      vsp();
      line(PPL, 1);
      line(PPL, 1);
      clr_pulse();

      // Short line 0, full line 1
      fill_rand(32);
      vsp();
      line(PPL - 1, 1);
      line(PPL, 1);
      clr_pulse();

      // Truncated frame, then a complete one
      fill_rand(64);
      vsp();
      line(PPL, 1);
      vsp();
      line(PPL, 1);
      line(PPL, 1);
      clr_pulse();

      // Sync reset mid-line at pixel 7, daten then ignored
      fq.delete();
      fill_rand(48);
      vsp();
      line(PPL, 1);
      for (int i = 0; i < 7; i++) begin
         cyc(1, 0, 1, 0);
         cyc(1, 1, 1, 0);
      end
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 1, 0);
         cyc(1, 0, 1, 0);
      end
      cyc(1, 0, 0, 0);
      vsp();
      line(PPL, 1);
      line(PPL, 1);

      // err_clr coinciding with a fresh underrun: set wins
      fq.delete();
      vsp();
      cyc(1, 0, 1, 0);
      g_clr = 1;
      cyc(1, 1, 1, 0);
      g_clr = 0;
      chk("underrun_set_wins", {31'd0, underrun}, 32'd1);
      line(PPL - 1, 1);
      line(PPL, 1);
      clr_pulse();
      chk("flags_cleared", {29'd0, underrun, len_err, frm_err}, 32'd0);

      // Random frames: random line lengths, gaps and FIFO depth
      for (int k = 0; k < 4; k++) begin
         fill_rand($urandom_range(20, 40));
         vsp();
         for (int l = 0; l < NL; l++)
            line($urandom_range(PPL - 2, PPL + 2), $urandom_range(0, 2));
         clr_pulse();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
